edge2pulse: RTL

EDGE2PULSE -- requirements
Module: edge2pulse

---
 rtl/edge2pulse.sv | 86 ++++++++
 1 files changed

// File: rtl/edge2pulse.sv
// Per-channel edge detector that emits a fixed-length pulse for each qualified edge.
// Define EDGE2PULSE_SYNC_EN to put a 2-flop synchronizer in front of each channel.
module edge2pulse #(
  parameter int DW     = 1,
  parameter int CW     = 4,
  parameter bit RETRIG = 1'b0
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [1:0]    mode,
  input  logic [CW-1:0] width,
  input  logic [DW-1:0] in,
  input  logic [DW-1:0] miss_clr,
  output logic [DW-1:0] out,
  output logic [DW-1:0] miss
);

  logic [DW-1:0] s;

`ifdef EDGE2PULSE_SYNC_EN
  logic [DW-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  assign s = in;
`endif

  logic [DW-1:0]         prev_q;
  logic [DW-1:0]         out_q, out_d;
  logic [DW-1:0]         miss_q, miss_d;
  logic [DW-1:0][CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]         ev;
  logic [CW-1:0]         load_val;

  // A zero width still produces a one-cycle pulse.
  assign load_val = (width == '0) ? CW'(1) : width;

  assign ev = ({DW{mode[0]}} &  s & ~prev_q)
            | ({DW{mode[1]}} & ~s &  prev_q);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    cnt_d  = cnt_q;
    miss_d = miss_q & ~miss_clr;
    out_d  = '0;
    for (int i = 0; i < DW; i++) begin
      if (ev[i] && (cnt_q[i] == '0 || RETRIG)) begin
        cnt_d[i] = load_val;
      end else begin
        if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CW'(1);
        // A dropped edge sets miss even when cleared in the same cycle.
        if (ev[i]) miss_d[i] = 1'b1;
      end
      out_d[i] = (cnt_d[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      prev_q <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
      miss_q <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop sees pre-edge values of the others.
      prev_q <= s;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      miss_q <= miss_d;
    end
  end

  assign out  = out_q;
  assign miss = miss_q;

endmodule
